// File: rtl/huffman_pkg.sv
// Shared constants and helpers for the Huffman decoder datapath.
//   DEFAULT_D_W            : default symbol / config bus width
//   NUM_OF_k_BIT_CHARS     : table capacity for code length k (2^k)
//   cnt_width(n)           : width of a fill counter that must hold 0..n
package huffman_pkg;

  localparam int unsigned DEFAULT_D_W = 8;

  localparam int unsigned NUM_OF_2_BIT_CHARS = 4;
  localparam int unsigned NUM_OF_3_BIT_CHARS = 8;
  localparam int unsigned NUM_OF_4_BIT_CHARS = 16;
  localparam int unsigned NUM_OF_5_BIT_CHARS = 32;
  localparam int unsigned NUM_OF_6_BIT_CHARS = 64;
  localparam int unsigned NUM_OF_7_BIT_CHARS = 128;
  localparam int unsigned NUM_OF_8_BIT_CHARS = 256;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/huffman_cam_entry.sv
// One (code, symbol) entry of the Huffman code-matching table.
//   clk, rst   : clock, synchronous active-high reset (clears valid)
//   clear      : drop the entry for a new configuration
//   load       : capture code_in/sym_in and mark the entry valid
//   d2check    : bit window compared against the stored code
//   hit        : entry valid and code equals d2check
//   sym        : stored symbol
module huffman_cam_entry #(
  parameter int unsigned C_W = 2,
  parameter int unsigned D_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           load,
  input  logic [C_W-1:0] code_in,
  input  logic [D_W-1:0] sym_in,
  input  logic [C_W-1:0] d2check,
  output logic           hit,
  output logic [D_W-1:0] sym
);

  logic           valid_q;
  logic [C_W-1:0] code_q;
  logic [D_W-1:0] sym_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
    end
  end

  // Contents need no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (load) begin
      code_q <= code_in;
      sym_q  <= sym_in;
    end
  end

  // valid_q first so an unknown d2check cannot leak through an empty entry.
  assign hit = valid_q && (code_q == d2check);
  assign sym = sym_q;

endmodule

// File: rtl/huffman_group_detect.sv
// Code-matching table for a single Huffman code length C_W.
//   clk, rst     : clock, synchronous active-high reset (empties the table)
//   d_conf       : symbol of the entry being written
//   h_conf       : right-aligned code, bits [C_W-1:0] used
//   w_conf       : code width of the offered entry; only C_W is accepted
//   en_conf      : config write strobe
//   new_conf     : empty the table (wins over en_conf)
//   d2check      : current C_W-bit bitstream window
//   code_matched : d2check equals a valid stored code
//   data_encoded : symbol of the lowest-index match, 0 if none
module huffman_group_detect
  import huffman_pkg::*;
#(
  parameter int unsigned NUM_OF_CHARS = 4,
  parameter int unsigned D_W          = DEFAULT_D_W,
  parameter int unsigned C_W          = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [D_W-1:0] d_conf,
  input  logic [D_W-1:0] h_conf,
  input  logic [D_W-1:0] w_conf,
  input  logic           en_conf,
  input  logic           new_conf,
  input  logic [C_W-1:0] d2check,
  output logic           code_matched,
  output logic [D_W-1:0] data_encoded
);

  localparam int unsigned CntW = cnt_width(NUM_OF_CHARS);

  logic [CntW-1:0]     cnt_q;
  logic                write_ok;
  logic [NUM_OF_CHARS-1:0] hit;
  logic [D_W-1:0]      sym_arr [NUM_OF_CHARS];

  // Writes for other code lengths belong to sibling instances; a full table drops writes.
  assign write_ok = en_conf && !new_conf && (w_conf == D_W'(C_W)) &&
                    (cnt_q < CntW'(NUM_OF_CHARS));

  always_ff @(posedge clk) begin
    if (rst || new_conf) begin
      cnt_q <= '0;
    end else if (write_ok) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_OF_CHARS; i++) begin : g_entry
    huffman_cam_entry #(
      .C_W (C_W),
      .D_W (D_W)
    ) u_entry (
      .clk     (clk),
      .rst     (rst),
      .clear   (new_conf),
      .load    (write_ok && (cnt_q == CntW'(i))),
      .code_in (h_conf[C_W-1:0]),
      .sym_in  (d_conf),
      .d2check (d2check),
      .hit     (hit[i]),
      .sym     (sym_arr[i])
    );
  end

  if (C_W < D_W) begin : g_unused
    logic unused_h_conf;
    assign unused_h_conf = ^h_conf[D_W-1:C_W];
  end

  // Scan from the top so the lowest-index hit is the last assignment and wins.
  always_comb begin
    code_matched = |hit;
    data_encoded = '0;
    for (int i = NUM_OF_CHARS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        data_encoded = sym_arr[i];
      end
    end
  end

endmodule

// File: tb/tb_huffman_group_detect.sv
module tb_huffman_group_detect;

  localparam int unsigned N   = 4;
  localparam int unsigned D_W = 8;
  localparam int unsigned C_W = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [D_W-1:0] d_conf, h_conf, w_conf;
  logic           en_conf, new_conf;
  logic [C_W-1:0] d2check;
  logic           code_matched;
  logic [D_W-1:0] data_encoded;

  huffman_group_detect #(
    .NUM_OF_CHARS (N),
    .D_W          (D_W),
    .C_W          (C_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .d_conf       (d_conf),
    .h_conf       (h_conf),
    .w_conf       (w_conf),
    .en_conf      (en_conf),
    .new_conf     (new_conf),
    .d2check      (d2check),
    .code_matched (code_matched),
    .data_encoded (data_encoded)
  );

  always #5 clk = ~clk;

  // Reference table: an ordered list of stored (code, symbol) pairs.
  logic [C_W-1:0] m_code [$];
  logic [D_W-1:0] m_sym  [$];

  // Scoreboard
  logic           exp_m [$];
  logic [D_W-1:0] exp_d [$];
  string          exp_n [$];

  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge clk) begin
    if (exp_m.size() > 0) begin
      logic           em;
      logic [D_W-1:0] ed;
      string          nm;
      em = exp_m.pop_front();
      ed = exp_d.pop_front();
      nm = exp_n.pop_front();
      n_cmp++;
      if ({code_matched, data_encoded} !== {em, ed}) begin
        n_bad++;
        $display("FAIL %s: got matched=%b data=%h, expected matched=%b data=%h (d2check=%b)",
                 nm, code_matched, data_encoded, em, ed, d2check);
      end
    end
  end

  // One cycle: drive inputs, optionally queue the expected lookup against the
  // current table, then advance the model by what the coming edge does.
  task automatic step(input logic r, input logic en, input logic nc,
                      input logic [D_W-1:0] w, input logic [D_W-1:0] h,
                      input logic [D_W-1:0] d, input logic [C_W-1:0] chk,
                      input logic do_chk, input string name);
    logic           m;
    logic [D_W-1:0] s;
    rst = r; en_conf = en; new_conf = nc;
    w_conf = w; h_conf = h; d_conf = d; d2check = chk;
    if (do_chk) begin
      m = 1'b0;
      s = '0;
      foreach (m_code[i]) begin
        if (!m && (m_code[i] === chk)) begin
          m = 1'b1;
          s = m_sym[i];
        end
      end
      exp_m.push_back(m);
      exp_d.push_back(s);
      exp_n.push_back(name);
    end
    if (r || nc) begin
      m_code.delete();
      m_sym.delete();
    end else if (en && (w == D_W'(C_W)) && (m_code.size() < N)) begin
      m_code.push_back(h[C_W-1:0]);
      m_sym.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [D_W-1:0] w, input logic [D_W-1:0] h, input logic [D_W-1:0] d);
    step(1'b0, 1'b1, 1'b0, w, h, d, 2'b00, 1'b0, "wr");
  endtask

  task automatic chk(input logic [C_W-1:0] c, input string name);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, c, 1'b1, name);
  endtask

  task automatic sweep(input string name);
    for (int i = 0; i < (1 << C_W); i++) chk(C_W'(i), name);
  endtask

  task automatic clr();
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, "clr");
  endtask

  initial begin
    rst = 1'b1; en_conf = 1'b0; new_conf = 1'b0;
    w_conf = '0; h_conf = '0; d_conf = '0; d2check = '0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1, "reset_out");
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'b11, 1'b1, "reset_out");
    sweep("reset_sweep");
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'bxx, 1'b1, "x_empty");

    // Basic two-entry table
    wr(8'd2, 8'h01, 8'h41);
    wr(8'd2, 8'h02, 8'h42);
    chk(2'b01, "basic_01");
    chk(2'b10, "basic_10");
    chk(2'b00, "basic_00");

    // Wrong width ignored
    clr();
    wr(8'd3, 8'h05, 8'h55);
    chk(2'b01, "wrong_width");
    sweep("wrong_width_sweep");

    // Capacity: fifth write dropped
    clr();
    for (int i = 0; i < 4; i++) wr(8'd2, 8'(i), 8'h10 + 8'(i));
    wr(8'd2, 8'h00, 8'h99);
    chk(2'b00, "capacity_00");
    sweep("capacity_sweep");

    // Duplicate codes: lowest index wins
    clr();
    wr(8'd2, 8'h03, 8'hAA);
    wr(8'd2, 8'h03, 8'hBB);
    chk(2'b11, "duplicate_11");

    // new_conf beats a simultaneous en_conf
    wr(8'd2, 8'h01, 8'h21);
    step(1'b0, 1'b1, 1'b1, 8'd2, 8'h00, 8'h66, 2'b11, 1'b1, "newconf_edge");
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'bxx, 1'b1, "x_after_clear");
    sweep("newconf_sweep");
    wr(8'd2, 8'h02, 8'h77);
    chk(2'b10, "newconf_reload");
    sweep("newconf_reload_sweep");

    // Same with reset mid-config
    wr(8'd2, 8'h00, 8'h31);
    wr(8'd2, 8'h01, 8'h32);
    step(1'b1, 1'b1, 1'b0, 8'd2, 8'h03, 8'h33, 2'b01, 1'b1, "rst_edge");
    sweep("rst_sweep");
    wr(8'd2, 8'h02, 8'h77);
    chk(2'b10, "rst_reload");
    sweep("rst_reload_sweep");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic           r, en, nc;
      logic [D_W-1:0] w;
      int             sel;
      r   = ($urandom_range(0, 99) < 2);
      nc  = ($urandom_range(0, 99) < 6);
      en  = ($urandom_range(0, 99) < 55);
      sel = $urandom_range(0, 9);
      w   = (sel < 6) ? 8'd2 : (sel < 8) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      step(r, en, nc, w, 8'($urandom), 8'($urandom), 2'($urandom), 1'b1, "random");
    end

    en_conf = 1'b0; new_conf = 1'b0; rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    if (exp_m.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected lookups never compared, required 0", exp_m.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/huffman_group_detect.md
# huffman_group_detect

Configurable code-matching table for one Huffman code length: it stores up to NUM_OF_CHARS (code, symbol) pairs of exactly C_W code bits. It reports whether the current C_W-bit window of the bitstream equals a stored code, and which symbol that code decodes to. One instance per code length sits inside the Huffman decoder datapath. The parent priority-selects among instances and advances its bit pointer in the same cycle the match is reported.

## Interface
- NUM_OF_CHARS, 4: table capacity (entries); ≥1.
- D_W, 8: symbol (decoded data) width; also width of the config buses.
- C_W, 2: code length handled by this instance; 1 ≤ C_W ≤ D_W.

- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- d_conf  in  D_W  config: symbol value of the entry being written.
- h_conf  in  D_W  config: Huffman code, right-aligned; bits [C_W-1:0] used, first-transmitted bit at C_W-1.
- w_conf  in  D_W  config: code width of the entry being offered.
- en_conf  in  1  config write strobe.
- new_conf  in  1  clear table for a new configuration.
- d2check  in  C_W  bit window to test; bit C_W-1 is the oldest stream bit.
- code_matched  out  1  1 when d2check equals a valid stored code.
- data_encoded  out  D_W  symbol of the matching entry; 0 when no match.

## Operation
- Storage per entry i: valid[i], code[i] (C_W bits), sym[i] (D_W bits). Also a fill counter cnt, width $clog2(NUM_OF_CHARS+1).
- Write: on a clock edge with en_conf=1, new_conf=0 and w_conf==C_W (full D_W-bit compare):
  - if cnt<NUM_OF_CHARS, entry cnt ← {valid=1, code=h_conf[C_W-1:0], sym=d_conf} and cnt increments;
  - if cnt==NUM_OF_CHARS, the write is silently dropped and the table is unchanged.
- Entries with any other w_conf value are ignored; they belong to other instances.
- Clear: new_conf=1 clears all valid bits and sets cnt=0. new_conf has priority over a simultaneous en_conf, which is discarded. Code/sym contents need not be cleared.
- Match (combinational): hit[i] = valid[i] && (code[i]==d2check).
  - code_matched = OR of hit.
  - data_encoded = sym of the lowest-index hit, 0 if none.
- Duplicate codes are legal; the lowest index wins.
- X on d2check while no entry is valid must still yield code_matched=0.

## Timing
- rst (synchronous): valid all 0, cnt=0. Outputs are therefore code_matched=0 and data_encoded=0 from the first edge of reset.
- Write latency: an entry written at edge k is matchable combinationally right after edge k.
- Match latency: zero cycles; outputs are a pure function of d2check and table state. No output registers.
- Clear at edge k: code_matched=0 from right after edge k, regardless of d2check.
- Reset or new_conf mid-stream: the table empties immediately and the parent sees no match until reconfigured.
- No handshake; config strobes are single-cycle qualified writes and back-to-back writes are allowed every cycle.

## Structure
- Shared package huffman_pkg:
  - default data width (8);
  - per-length capacity constants: NUM_OF_k_BIT_CHARS = 2^k for k=2..8;
  - a function returning the fill-counter width.
- One natural sub-module, huffman_cam_entry:
  - holds valid/code/sym for one entry;
  - takes load, clear and d2check inputs;
  - outputs hit and sym.
- The top generates NUM_OF_CHARS entries and adds a fixed-priority hit/sym mux plus the fill counter.

## Test plan
- Reset, then d2check sweeps all values -> code_matched=0, data_encoded=0 throughout.
- C_W=2: write (w=2,h=2'b01,d=8'h41), then (w=2,h=2'b10,d=8'h42). d2check=01 -> matched=1, data=41; 10 -> 1, 42; 00 -> 0, 00.
- C_W=2: a write with w_conf=3 (h=3'b101) -> table unchanged; d2check=01 -> no match.
- Capacity: NUM_OF_CHARS=4, write codes 00, 01, 10, 11 with data 10..13, then a fifth write (code 00, data 99) -> dropped; d2check=00 -> data 10.
- Duplicate code 11 written with data AA then BB -> d2check=11 gives AA.
- new_conf with simultaneous en_conf after a loaded table -> all lookups miss. A following write lands in entry 0 and matches next cycle. Repeat the same sequence with rst asserted mid-config -> identical empty result.
